fb_write_arbiter: RTL

Shares the double-buffered 32x16 panel framebuffer between two pixel sources, e.g. the pattern generator and a host image loader. Grants one requester a whole frame at a time and steers its writes into the back page. Swaps display pages on the scan-out vertical blank once the frame is complete. Sits between the pixel sources and the framebuffer write port; display_page drives the scan-out controller.

---
 rtl/fb_write_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
// Arbitrates two pixel sources onto the write port of a double-buffered
// framebuffer. One requester owns a whole frame at a time; its pixels are
// written into the back page (~display_page). Once the frame's last pixel is
// written, the pages swap on the next scan-out vertical blank. An owner that
// stays idle for TIMEOUT consecutive grant cycles loses the grant.
//
// Ports:
//   pixclk, reset            clock, asynchronous active-high reset
//   reqN_valid/addr/rgb/last requester N pixel stream (N = 0, 1)
//   reqN_ready               requester N pixel accepted when valid
//   vblank                   one-cycle end-of-displayed-frame pulse
//   fb_we/fb_addr/fb_data    registered framebuffer write port
//   display_page             page currently scanned out
//   owner                    current/last granted requester
//   swap_pending             frame complete, waiting for vblank
//   swap_done                one-cycle pulse on page swap
//   abort                    one-cycle pulse on timeout revoke
module fb_write_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 1023
) (
  input  logic              pixclk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_rgb,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_rgb,
  input  logic              req1_last,
  output logic              req1_ready,
  input  logic              vblank,
  output logic              fb_we,
  output logic [ADDR_W:0]   fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              display_page,
  output logic              owner,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              abort
);

  // Counter only needs to count up to TIMEOUT-1; reaching that value on an
  // idle cycle is the TIMEOUT-th idle cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_SWAP} state_t;

  state_t            state, state_next;
  logic              owner_next, page_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              fb_we_next, swap_done_next, abort_next;
  logic [ADDR_W:0]   fb_addr_next;
  logic [DATA_W-1:0] fb_data_next;

  logic              sel_valid, sel_last, accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_rgb;

  assign req0_ready   = (state == GRANT) && !owner;
  assign req1_ready   = (state == GRANT) && owner;
  assign swap_pending = (state == WAIT_SWAP);

  assign sel_valid = owner ? req1_valid : req0_valid;
  assign sel_addr  = owner ? req1_addr  : req0_addr;
  assign sel_rgb   = owner ? req1_rgb   : req0_rgb;
  assign sel_last  = owner ? req1_last  : req0_last;
  assign accept    = (state == GRANT) && sel_valid;

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= 1'b1;
      display_page <= 1'b0;
      cnt          <= '0;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
      swap_done    <= 1'b0;
      abort        <= 1'b0;
    end else begin
      state        <= state_next;
      owner        <= owner_next;
      display_page <= page_next;
      cnt          <= cnt_next;
      fb_we        <= fb_we_next;
      fb_addr      <= fb_addr_next;
      fb_data      <= fb_data_next;
      swap_done    <= swap_done_next;
      abort        <= abort_next;
    end
  end

  always_comb begin
    state_next     = state;
    owner_next     = owner;
    page_next      = display_page;
    cnt_next       = '0;
    fb_we_next     = 1'b0;
    fb_addr_next   = fb_addr;
    fb_data_next   = fb_data;
    swap_done_next = 1'b0;
    abort_next     = 1'b0;
    unique case (state)
      IDLE: begin
        // Tie goes to the requester that did not own the previous grant.
        if (req0_valid && req1_valid) begin
          owner_next = ~owner;
          state_next = GRANT;
        end else if (req0_valid) begin
          owner_next = 1'b0;
          state_next = GRANT;
        end else if (req1_valid) begin
          owner_next = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          fb_we_next   = 1'b1;
          fb_addr_next = {~display_page, sel_addr};
          fb_data_next = sel_rgb;
          if (sel_last) state_next = WAIT_SWAP;
        end else if (TIMEOUT > 0) begin
          if (cnt == CNT_LAST) begin
            abort_next = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      WAIT_SWAP: begin
        if (vblank) begin
          page_next      = ~display_page;
          swap_done_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
